// File: rtl/sram_macro_pkg.sv
// Shared macro geometry and sizing helpers for the banked SRAM built from
// 16x256 single-port macros.
package sram_macro_pkg;

  localparam int MACRO_WIDTH  = 16;
  localparam int MACRO_DEPTH  = 256;
  localparam int MACRO_ADDR_W = 8;

  typedef enum logic {
    ST_IDLE,
    ST_MERGE
  } state_e;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  function automatic int num_cols(input int data_width);
    return ceil_div(data_width, MACRO_WIDTH);
  endfunction

  function automatic int num_banks(input int num_words);
    return ceil_div(num_words, MACRO_DEPTH);
  endfunction

  function automatic int be_width(input int data_width);
    return ceil_div(data_width, 8);
  endfunction

endpackage

// File: rtl/sram_asap7_16x256_1rw.sv
// Behavioural stand-in for the 16x256 single-port macro: active-low chip
// enable and write enable, registered read data that only changes on reads.
module sram_asap7_16x256_1rw (
  input  logic        clk,
  input  logic        ce_in,
  input  logic        we_in,
  input  logic [7:0]  addr_in,
  input  logic [15:0] wd_in,
  output logic [15:0] rd_out
);

  logic [15:0] mem [256];

  always_ff @(posedge clk) begin
    if (!ce_in) begin
      if (!we_in) mem[addr_in] <= wd_in;
      else        rd_out       <= mem[addr_in];
    end
  end

endmodule

// File: rtl/sram_macro_row.sv
// One bank of the banked RAM: COLS macros side by side sharing enable,
// write enable and row address.
module sram_macro_row
  import sram_macro_pkg::*;
#(
  parameter int COLS = 4
) (
  input  logic                          clk,
  input  logic                          ce_n,
  input  logic                          we_n,
  input  logic [MACRO_ADDR_W-1:0]       addr,
  input  logic [COLS*MACRO_WIDTH-1:0]   wdata,
  output logic [COLS*MACRO_WIDTH-1:0]   rdata
);

  for (genvar c = 0; c < COLS; c++) begin : g_col
    sram_asap7_16x256_1rw u_macro (
      .clk     (clk),
      .ce_in   (ce_n),
      .we_in   (we_n),
      .addr_in (addr),
      .wd_in   (wdata[c*MACRO_WIDTH +: MACRO_WIDTH]),
      .rd_out  (rdata[c*MACRO_WIDTH +: MACRO_WIDTH])
    );
  end

endmodule

// File: rtl/sram_rmw_banked_ram.sv
// Banked single-port RAM with byte-enable writes done as read-modify-write,
// a grant/valid handshake and out-of-range address detection.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | granting; reads, full writes and RMW-reads issued directly
//   ST_MERGE | stalled; merge read data with latched bytes and write back
module sram_rmw_banked_ram
  import sram_macro_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WORDS  = 256,
  parameter int ADDR_WIDTH = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  parameter int BE_WIDTH   = be_width(DATA_WIDTH)
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  CSel_SI,
  input  logic                  WrEn_SI,
  input  logic [BE_WIDTH-1:0]   BEn_SI,
  input  logic [DATA_WIDTH-1:0] WrData_DI,
  input  logic [ADDR_WIDTH-1:0] Addr_DI,
  output logic                  Gnt_SO,
  output logic                  RdValid_DO,
  output logic [DATA_WIDTH-1:0] RdData_DO,
  output logic                  Err_SO
);

  localparam int COLS   = num_cols(DATA_WIDTH);
  localparam int BANKS  = num_banks(NUM_WORDS);
  localparam int PAD_W  = COLS * MACRO_WIDTH;
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam logic [ADDR_WIDTH:0] NUM_WORDS_L = (ADDR_WIDTH+1)'(NUM_WORDS);

  state_e                  state;
  logic [BANK_W-1:0]       bank_q;
  logic [MACRO_ADDR_W-1:0] row_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [BE_WIDTH-1:0]     ben_q;
  logic                    oor_q;
  logic [DATA_WIDTH-1:0]   last_q;

  logic [BANK_W-1:0]       req_bank;
  logic [MACRO_ADDR_W-1:0] req_row;
  logic                    req_in_range;
  logic                    accept;
  logic                    be_full;
  logic                    be_none;

  logic [BANKS-1:0]        bank_en;
  logic [BANKS-1:0]        bank_ce_n;
  logic                    mem_we_n;
  logic [MACRO_ADDR_W-1:0] mem_row;
  logic [PAD_W-1:0]        mem_wdata;
  logic [PAD_W-1:0]        bank_rdata [BANKS];
  logic [PAD_W-1:0]        sel_rdata;
  logic [PAD_W-1:0]        merged;

  function automatic logic [BANKS-1:0] bank_onehot(input logic [BANK_W-1:0] b);
    logic [BANKS-1:0] oh;
    oh = '0;
    for (int i = 0; i < BANKS; i++) begin
      if (b == BANK_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  if (ADDR_WIDTH > MACRO_ADDR_W) begin : g_banked_addr
    assign req_bank = BANK_W'(Addr_DI[ADDR_WIDTH-1:MACRO_ADDR_W]);
    assign req_row  = Addr_DI[MACRO_ADDR_W-1:0];
  end else begin : g_flat_addr
    assign req_bank = '0;
    assign req_row  = MACRO_ADDR_W'(Addr_DI);
  end

  assign req_in_range = {1'b0, Addr_DI} < NUM_WORDS_L;
  assign accept       = CSel_SI & Gnt_SO;
  assign be_full      = &BEn_SI;
  assign be_none      = ~|BEn_SI;

  always_comb begin
    sel_rdata = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (bank_q == BANK_W'(b)) sel_rdata = bank_rdata[b];
    end
  end

  // Bytes not enabled keep what the RMW read returned; padding stays zero.
  always_comb begin
    merged = '0;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      merged[b] = ben_q[b/8] ? wdata_q[b] : sel_rdata[b];
    end
  end

  always_comb begin
    bank_en   = '0;
    mem_we_n  = 1'b1;
    mem_row   = req_row;
    mem_wdata = PAD_W'(WrData_DI);
    if (state == ST_MERGE) begin
      bank_en   = bank_onehot(bank_q);
      mem_we_n  = 1'b0;
      mem_row   = row_q;
      mem_wdata = merged;
    end else if (accept && req_in_range) begin
      if (!WrEn_SI) begin
        bank_en = bank_onehot(req_bank);
      end else if (be_full) begin
        bank_en  = bank_onehot(req_bank);
        mem_we_n = 1'b0;
      end else if (!be_none) begin
        bank_en = bank_onehot(req_bank);
      end
    end
  end

  // Reset gates the enables so nothing is written while reset is held.
  assign bank_ce_n = ~(bank_en & {BANKS{Rst_RBI}});

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    sram_macro_row #(
      .COLS (COLS)
    ) u_row (
      .clk   (Clk_CI),
      .ce_n  (bank_ce_n[b]),
      .we_n  (mem_we_n),
      .addr  (mem_row),
      .wdata (mem_wdata),
      .rdata (bank_rdata[b])
    );
  end

  if (PAD_W > DATA_WIDTH) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^sel_rdata[PAD_W-1:DATA_WIDTH];
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state      <= ST_IDLE;
      Gnt_SO     <= 1'b1;
      RdValid_DO <= 1'b0;
      Err_SO     <= 1'b0;
      oor_q      <= 1'b0;
      bank_q     <= '0;
      row_q      <= '0;
      wdata_q    <= '0;
      ben_q      <= '0;
      last_q     <= '0;
    end else begin
      RdValid_DO <= 1'b0;
      Err_SO     <= 1'b0;
      if (RdValid_DO) last_q <= RdData_DO;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (!req_in_range) begin
              Err_SO <= 1'b1;
              if (!WrEn_SI) begin
                RdValid_DO <= 1'b1;
                oor_q      <= 1'b1;
              end
            end else if (!WrEn_SI) begin
              RdValid_DO <= 1'b1;
              oor_q      <= 1'b0;
              bank_q     <= req_bank;
            end else if (!be_full && !be_none) begin
              bank_q  <= req_bank;
              row_q   <= req_row;
              wdata_q <= WrData_DI;
              ben_q   <= BEn_SI;
              state   <= ST_MERGE;
              Gnt_SO  <= 1'b0;
            end
          end
        end
        ST_MERGE: begin
          state  <= ST_IDLE;
          Gnt_SO <= 1'b1;
        end
        default: begin
          state  <= ST_IDLE;
          Gnt_SO <= 1'b1;
        end
      endcase
    end
  end

  // Read data is live only during the valid pulse and held afterwards.
  always_comb begin
    if (RdValid_DO) RdData_DO = oor_q ? '0 : sel_rdata[DATA_WIDTH-1:0];
    else            RdData_DO = last_q;
  end

endmodule
